chip: RTL and testbench

- Top-level test chip: wraps the existing combinational/sequential circuit-under-test (CUT, 35 inputs, 49 outputs) with a self-contained logic BIST.
- System mode: primary inputs drive the CUT directly.
- BIST mode: an on-chip LFSR drives the CUT, a MISR compacts its outputs, and a controller compares the final signature to a golden constant, reporting done/pass on two pins.

---
 rtl/chip.sv | 123 ++++++++++++
 tb/tb_chip.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip.sv
// Logic-BIST test chip: LFSR stimulus, MISR compaction and a pass/fail controller around the CUT.
// Optional BIST_SIG_OUT_EN: in DONE with bistmode=1, po shows the MISR signature for golden extraction.

module chip_cut (
    input  logic        clk,
    input  logic        rst,
    input  logic [34:0] stim,
    output logic [48:0] resp
);
    logic        g_and;
    logic        g_or;
    logic [16:0] sum;
    logic [7:0]  acc;

    assign g_and = stim[3] & stim[7];
    assign g_or  = stim[12] | stim[20];
    assign sum   = {1'b0, stim[15:0]} + {1'b0, stim[31:16]};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) acc <= '0;
        else     acc <= {acc[6:0], acc[7]} ^ stim[34:27];
    end

    assign resp = {acc, sum, g_and, g_or, stim[21:0] ^ stim[34:13]};
endmodule

module chip #(
    parameter int          NUM_PATTERNS = 4096,
    parameter logic [34:0] LFSR_SEED    = 35'h0_0000_0001,
    parameter logic [48:0] GOLDEN_SIG   = 49'h0,
    parameter int          CNT_W        = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [34:0] pi,
    output logic [48:0] po,
    input  logic        bistmode,
    output logic        bistdone,
    output logic        bistpass
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_next;
    logic [34:0]        lfsr, lfsr_next, cut_in;
    logic [48:0]        misr, misr_next, misr_step, cut_po;
    logic [CNT_W-1:0]   cnt, cnt_next;

    assign cut_in = bistmode ? lfsr : pi;

    chip_cut circuit (
        .clk  (clk),
        .rst  (rst),
        .stim (cut_in),
        .resp (cut_po)
    );

    // x^49+x^9+1: rotate, absorb CUT response, feedback also lands on bit 9
    assign misr_step = {misr[47:0], misr[48]} ^ cut_po ^ {39'b0, misr[48], 9'b0};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        lfsr_next  = lfsr;
        misr_next  = misr;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                lfsr_next = LFSR_SEED;
                misr_next = '0;
                cnt_next  = '0;
                if (bistmode) state_next = RUN;
            end
            RUN: begin
                if (!bistmode) begin
                    state_next = IDLE;
                    lfsr_next  = LFSR_SEED;
                    misr_next  = '0;
                    cnt_next   = '0;
                end else begin
                    misr_next = misr_step;
                    lfsr_next = {lfsr[33:0], lfsr[34] ^ lfsr[1]};
                    cnt_next  = cnt + CNT_W'(1);
                    if (cnt == CNT_W'(NUM_PATTERNS - 1)) state_next = DONE;
                end
            end
            DONE: begin
                if (!bistmode) begin
                    state_next = IDLE;
                    lfsr_next  = LFSR_SEED;
                    misr_next  = '0;
                    cnt_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lfsr     <= LFSR_SEED;
            misr     <= '0;
            cnt      <= '0;
            bistdone <= 1'b0;
            bistpass <= 1'b0;
        end else begin
            state    <= state_next;
            lfsr     <= lfsr_next;
            misr     <= misr_next;
            cnt      <= cnt_next;
            // flags track the state being entered so they rise on the same edge as DONE
            bistdone <= (state_next == DONE);
            bistpass <= (state_next == DONE) && (misr_next == GOLDEN_SIG);
        end
    end

`ifdef BIST_SIG_OUT_EN
    assign po = (state == DONE && bistmode) ? misr : cut_po;
`else
    assign po = cut_po;
`endif
endmodule

// File: tb/tb_chip.sv
// Directed self-checking bench for chip: system mode, BIST runs, stuck-at faults, reset and mode aborts.

module tb_chip;
    localparam int          NP   = 200;
    localparam logic [34:0] SEED = 35'h0_0000_0001;

    typedef struct packed {
        logic [48:0] sig;
        logic [48:0] po;
    } model_t;

    function automatic logic [48:0] m_cut(input logic [34:0] a, input logic [7:0] acc);
        logic [16:0] s;
        s = {1'b0, a[15:0]} + {1'b0, a[31:16]};
        return {acc, s, a[3] & a[7], a[12] | a[20], a[21:0] ^ a[34:13]};
    endfunction

    function automatic logic [7:0] m_acc(input logic [7:0] acc, input logic [34:0] a);
        return {acc[6:0], acc[7]} ^ a[34:27];
    endfunction

    function automatic logic [34:0] m_lfsr(input logic [34:0] l);
        return {l[33:0], l[34] ^ l[1]};
    endfunction

    function automatic logic [48:0] m_misr(input logic [48:0] m, input logic [48:0] r);
        return {m[47:0], m[48]} ^ r ^ {39'b0, m[48], 9'b0};
    endfunction

    // fault-free signature and the CUT response seen in the first DONE cycle
    function automatic model_t run_model();
        model_t      res;
        logic [34:0] l;
        logic [7:0]  acc;
        logic [48:0] m;
        l   = SEED;
        acc = m_acc(8'h00, l);
        m   = '0;
        for (int j = 0; j < NP; j++) begin
            m   = m_misr(m, m_cut(l, acc));
            acc = m_acc(acc, l);
            l   = m_lfsr(l);
        end
        res.sig = m;
        res.po  = m_cut(l, acc);
        return res;
    endfunction

    localparam model_t      MODEL  = run_model();
    localparam logic [48:0] GOLDEN = MODEL.sig;
`ifdef BIST_SIG_OUT_EN
    localparam logic [48:0] DONE_PO = GOLDEN;
`else
    localparam logic [48:0] DONE_PO = MODEL.po;
`endif

    logic        clk, rst, bistmode, bistdone, bistpass;
    logic [34:0] pi;
    logic [48:0] po;
    int          tests_run, tests_failed;

    chip #(
        .NUM_PATTERNS (NP),
        .LFSR_SEED    (SEED),
        .GOLDEN_SIG   (GOLDEN),
        .CNT_W        (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .pi       (pi),
        .po       (po),
        .bistmode (bistmode),
        .bistdone (bistdone),
        .bistpass (bistpass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        bistmode = 1'b1;
        rst      = 1'b1;
        step();
        rst      = 1'b0;
    endtask

    task automatic wait_done(output int edges, output logic early_pass);
        edges      = -1;
        early_pass = 1'b0;
        for (int n = 1; n <= NP + 20; n++) begin
            step();
            if (bistdone === 1'b1) begin
                edges = n;
                break;
            end
            if (bistpass !== 1'b0) early_pass = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bistmode = 1'b0; pi = '0;
        step();
        tests_run++;
        if (bistdone !== 1'b0 || bistpass !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: done=%b pass=%b, want 0 0", bistdone, bistpass);
        end
        tests_run++;
        if (po !== 49'h0) begin
            tests_failed++;
            $display("FAIL reset_po: got %h want 0", po);
        end
    endtask

    task automatic test_system();
        logic [34:0] vecs [6];
        logic [7:0]  acc;
        vecs[0] = 35'h7_FFFF_FFFF; vecs[1] = 35'h0_0000_0088; vecs[2] = 35'h5_5555_5555;
        vecs[3] = 35'h2_AAAA_AAAA; vecs[4] = 35'h0_FFFF_0001; vecs[5] = 35'h4_0010_1000;
        rst = 1'b1; bistmode = 1'b0;
        step();
        rst = 1'b0;
        acc = 8'h00;
        for (int i = 0; i < 6; i++) begin
            pi = vecs[i];
            #1;
            tests_run++;
            if (po !== m_cut(vecs[i], acc)) begin
                tests_failed++;
                $display("FAIL system_po[%0d]: got %h want %h", i, po, m_cut(vecs[i], acc));
            end
            tests_run++;
            if (bistdone !== 1'b0 || bistpass !== 1'b0) begin
                tests_failed++;
                $display("FAIL system_flags[%0d]: done=%b pass=%b want 0 0", i, bistdone, bistpass);
            end
            step();
            acc = m_acc(acc, vecs[i]);
        end
    endtask

    task automatic test_bist_pass();
        int   e;
        logic ep;
        for (int r = 0; r < 2; r++) begin
            start_run();
            wait_done(e, ep);
            tests_run++;
            if (e != NP + 1) begin
                tests_failed++;
                $display("FAIL bist_latency[%0d]: got %0d edges want %0d", r, e, NP + 1);
            end
            tests_run++;
            if (ep !== 1'b0) begin
                tests_failed++;
                $display("FAIL bist_early_pass[%0d]: pass seen before done", r);
            end
            tests_run++;
            if (bistpass !== 1'b1) begin
                tests_failed++;
                $display("FAIL bist_pass[%0d]: got %b want 1", r, bistpass);
            end
            tests_run++;
            if (po !== DONE_PO) begin
                tests_failed++;
                $display("FAIL bist_done_po[%0d]: got %h want %h", r, po, DONE_PO);
            end
            for (int k = 0; k < 3; k++) step();
            tests_run++;
            if (bistdone !== 1'b1 || bistpass !== 1'b1 || po[40:0] !== DONE_PO[40:0]) begin
                tests_failed++;
                $display("FAIL bist_hold[%0d]: done=%b pass=%b po=%h", r, bistdone, bistpass, po);
            end
        end
    endtask

    task automatic test_stuck_at();
        int   e;
        logic ep;
        for (int v = 0; v < 3; v++) begin
            if (v == 0) force dut.circuit.g_and = 1'b0;
            if (v == 1) force dut.circuit.g_and = 1'b1;
            start_run();
            wait_done(e, ep);
            release dut.circuit.g_and;
            tests_run++;
            if (e != NP + 1) begin
                tests_failed++;
                $display("FAIL stuck_latency[%0d]: got %0d want %0d", v, e, NP + 1);
            end
            tests_run++;
            if (bistpass !== (v == 2)) begin
                tests_failed++;
                $display("FAIL stuck_pass[%0d]: got %b want %b", v, bistpass, v == 2);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int   e;
        logic ep;
        start_run();
        for (int k = 0; k < 100; k++) step();
        rst = 1'b1;
        step();
        tests_run++;
        if (bistdone !== 1'b0 || bistpass !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_flags: done=%b pass=%b want 0 0", bistdone, bistpass);
        end
        rst = 1'b0;
        wait_done(e, ep);
        tests_run++;
        if (e != NP + 1 || bistpass !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_rerun: edges=%0d pass=%b want %0d 1", e, bistpass, NP + 1);
        end
    endtask

    task automatic test_mode_drop();
        int          e;
        logic        ep;
        logic [34:0] v;
        logic [48:0] want;
        for (int p = 0; p < 2; p++) begin
            start_run();
            if (p == 0) for (int k = 0; k < 50; k++) step();
            else wait_done(e, ep);
            v        = (p == 0) ? 35'h1_2345_6789 : 35'h6_DCBA_0F0F;
            want     = m_cut(v, 8'h00);
            bistmode = 1'b0;
            pi       = v;
            step();
            tests_run++;
            if (bistdone !== 1'b0 || bistpass !== 1'b0) begin
                tests_failed++;
                $display("FAIL drop_flags[%0d]: done=%b pass=%b want 0 0", p, bistdone, bistpass);
            end
            tests_run++;
            if (po[40:0] !== want[40:0]) begin
                tests_failed++;
                $display("FAIL drop_po[%0d]: got %h want %h", p, po[40:0], want[40:0]);
            end
            for (int k = 0; k < 3; k++) step();
            tests_run++;
            if (bistdone !== 1'b0) begin
                tests_failed++;
                $display("FAIL drop_idle[%0d]: done=%b want 0", p, bistdone);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        bistmode     = 1'b0;
        pi           = '0;
        test_reset();
        test_system();
        test_bist_pass();
        test_stuck_at();
        test_reset_mid_run();
        test_mode_drop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
